// File: rtl/hcm_address_arbiter.sv
// Round-robin arbiter for the single hit-count-memory address port.
// Each cycle that storageReady is high, at most one requester is granted. The
// winner's address is registered onto the HCM port with a one-cycle strobe.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   storageReady      HCM can accept an address this cycle
//   reqValid[i]       requester i presents a valid address
//   reqAddress        requester i address in [i*ADDRBITS +: ADDRBITS]
//   reqAck            one-hot, one-cycle acknowledge of the served requester
//   address           registered address to the HCM
//   newAddress        one-cycle strobe qualifying address
//   grantIndex        index of the requester behind the current strobe
//   grantCount        saturating count of grants since reset
module hcm_address_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ADDRBITS = 8,
    parameter int unsigned CNTBITS  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     storageReady,
    input  logic [NREQ-1:0]          reqValid,
    input  logic [NREQ*ADDRBITS-1:0] reqAddress,
    output logic [NREQ-1:0]          reqAck,
    output logic [ADDRBITS-1:0]      address,
    output logic                     newAddress,
    output logic [2:0]               grantIndex,
    output logic [CNTBITS-1:0]       grantCount
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]       ptr;
    logic [NREQ-1:0]     eligible;
    logic                found;
    logic [PW-1:0]       win;
    logic [PW-1:0]       idx;
    logic [PW-1:0]       ptr_next;
    logic [ADDRBITS-1:0] win_addr;
    logic [NREQ-1:0]     win_onehot;

    // Circular scan from the priority pointer; a requester in its ack cycle is masked out.
    always_comb begin
        eligible   = reqValid & ~reqAck;
        found      = 1'b0;
        win        = '0;
        idx        = '0;
        win_addr   = '0;
        win_onehot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win == PW'(k)) begin
                win_addr      = reqAddress[k*ADDRBITS +: ADDRBITS];
                win_onehot[k] = 1'b1;
            end
        end
        // Pointer wraps modulo NREQ, which need not be a power of two.
        ptr_next = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end

    // Grant register: address, strobe, ack, pointer and counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            address    <= '0;
            newAddress <= 1'b0;
            reqAck     <= '0;
            grantIndex <= '0;
            grantCount <= '0;
        end else if (storageReady && found) begin
            ptr        <= ptr_next;
            address    <= win_addr;
            newAddress <= 1'b1;
            reqAck     <= win_onehot;
            grantIndex <= 3'(win);
            if (grantCount != '1) begin
                grantCount <= grantCount + CNTBITS'(1);
            end
        end else begin
            newAddress <= 1'b0;
            reqAck     <= '0;
        end
    end

endmodule
